// File: rtl/piece_mover_if.sv
// Collision-check handshake between the piece mover (master) and the board checker (slave).
interface piece_mover_if #(
    parameter int X_W = 4,
    parameter int Y_W = 5
) ();
    logic           chk_req;
    logic [X_W-1:0] chk_x;
    logic [Y_W-1:0] chk_y;
    logic [1:0]     chk_rot;
    logic           chk_ack;
    logic           chk_ok;

    modport master (output chk_req, chk_x, chk_y, chk_rot, input chk_ack, chk_ok);
    modport slave  (input chk_req, chk_x, chk_y, chk_rot, output chk_ack, chk_ok);
endinterface

// File: rtl/piece_mover.sv
// Turns gravity/lateral ticks and player buttons into checked piece moves; tracks lock, spawn and game-over.
// Optional feature macro: SOFT_DROP_EN (h_tick with btn_drop alone proposes a downward move).
module piece_mover #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 4,
    parameter int SPAWN_Y = 0,
    parameter int X_W     = 4,
    parameter int Y_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic            spawn,
    input  logic            v_tick,
    input  logic            h_tick,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_rot,
    input  logic            btn_drop,
    piece_mover_if.master   chk,
    output logic [X_W-1:0]  piece_x,
    output logic [Y_W-1:0]  piece_y,
    output logic [1:0]      piece_rot,
    output logic            piece_live,
    output logic            lock,
    output logic            game_over
);
    localparam logic [X_W-1:0] X_ZERO  = {X_W{1'b0}};
    localparam logic [X_W-1:0] X_ONE   = X_W'(1'b1);
    localparam logic [X_W-1:0] X_LAST  = X_W'(BOARD_W - 32'd1);
    localparam logic [X_W-1:0] X_SPAWN = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1'b1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(BOARD_H - 32'd1);
    localparam logic [Y_W-1:0] Y_SPAWN = Y_W'(SPAWN_Y);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_CHECK = 2'd2, S_LOCK = 2'd3} state_t;
    typedef enum logic [1:0] {K_SPAWN = 2'd0, K_DOWN = 2'd1, K_OTHER = 2'd2} kind_t;

    state_t         state_q, state_d;
    kind_t          kind_q, kind_d;
    logic           chk_req_q, chk_req_d;
    logic [X_W-1:0] chk_x_q, chk_x_d;
    logic [Y_W-1:0] chk_y_q, chk_y_d;
    logic [1:0]     chk_rot_q, chk_rot_d;
    logic [X_W-1:0] piece_x_q, piece_x_d;
    logic [Y_W-1:0] piece_y_q, piece_y_d;
    logic [1:0]     piece_rot_q, piece_rot_d;
    logic           piece_live_q, piece_live_d;
    logic           lock_q, lock_d;
    logic           game_over_q, game_over_d;
    logic           pending_v_q, pending_v_d;
    logic           rot_pend_q, rot_pend_d;
    logic           btn_rot_prev_q, btn_rot_prev_d;

    logic rot_edge_s, rot_now_s, v_live_s, left_only_s, right_only_s, drop_s;

`ifdef SOFT_DROP_EN
    assign drop_s = h_tick & btn_drop & ~btn_left & ~btn_right;
`else
    logic unused_btn_drop_s;
    assign unused_btn_drop_s = btn_drop;
    assign drop_s            = 1'b0;
`endif

    assign rot_edge_s   = btn_rot & ~btn_rot_prev_q;
    assign rot_now_s    = rot_pend_q | rot_edge_s;
    assign v_live_s     = v_tick & active;
    assign left_only_s  = btn_left & ~btn_right;
    assign right_only_s = btn_right & ~btn_left;

    // Next-state and next-output logic for the move/check FSM.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        chk_req_d      = chk_req_q;
        chk_x_d        = chk_x_q;
        chk_y_d        = chk_y_q;
        chk_rot_d      = chk_rot_q;
        piece_x_d      = piece_x_q;
        piece_y_d      = piece_y_q;
        piece_rot_d    = piece_rot_q;
        piece_live_d   = piece_live_q;
        lock_d         = 1'b0;
        game_over_d    = game_over_q;
        pending_v_d    = pending_v_q;
        rot_pend_d     = rot_pend_q | rot_edge_s;
        btn_rot_prev_d = btn_rot;

        case (state_q)
            S_IDLE: begin
                pending_v_d = pending_v_q | v_live_s;
                if (spawn && !game_over_q) begin
                    {chk_x_d, chk_y_d, chk_rot_d} = {X_SPAWN, Y_SPAWN, 2'd0};
                    kind_d    = K_SPAWN;
                    chk_req_d = 1'b1;
                    state_d   = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READY: begin
                if (!active) begin
                    state_d = S_READY;
                end else if (v_tick || pending_v_q || drop_s) begin
                    // Gravity (and soft drop) outrank lateral moves; the bottom row locks without asking.
                    pending_v_d = 1'b0;
                    if (drop_s && !(v_tick || pending_v_q)) begin
                        rot_pend_d = 1'b0;
                    end else begin
                        rot_pend_d = rot_pend_q | rot_edge_s;
                    end
                    if (piece_y_q == Y_LAST) begin
                        lock_d       = 1'b1;
                        piece_live_d = 1'b0;
                        state_d      = S_LOCK;
                    end else begin
                        {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q, piece_y_q + Y_ONE, piece_rot_q};
                        kind_d    = K_DOWN;
                        chk_req_d = 1'b1;
                        state_d   = S_CHECK;
                    end
                end else if (h_tick) begin
                    rot_pend_d = 1'b0;
                    if (left_only_s) begin
                        if (piece_x_q != X_ZERO) begin
                            {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q - X_ONE, piece_y_q, piece_rot_q};
                            kind_d    = K_OTHER;
                            chk_req_d = 1'b1;
                            state_d   = S_CHECK;
                        end else begin
                            state_d = S_READY;
                        end
                    end else if (right_only_s) begin
                        if (piece_x_q != X_LAST) begin
                            {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q + X_ONE, piece_y_q, piece_rot_q};
                            kind_d    = K_OTHER;
                            chk_req_d = 1'b1;
                            state_d   = S_CHECK;
                        end else begin
                            state_d = S_READY;
                        end
                    end else if (rot_now_s) begin
                        {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q, piece_y_q, piece_rot_q + 2'd1};
                        kind_d    = K_OTHER;
                        chk_req_d = 1'b1;
                        state_d   = S_CHECK;
                    end else begin
                        state_d = S_READY;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_CHECK: begin
                pending_v_d = pending_v_q | v_live_s;
                if (chk.chk_ack) begin
                    chk_req_d = 1'b0;
                    if (chk.chk_ok) begin
                        {piece_x_d, piece_y_d, piece_rot_d} = {chk_x_q, chk_y_q, chk_rot_q};
                        piece_live_d = 1'b1;
                        state_d      = S_READY;
                    end else begin
                        case (kind_q)
                            K_SPAWN: begin
                                game_over_d = 1'b1;
                                pending_v_d = 1'b0;
                                state_d     = S_IDLE;
                            end
                            K_DOWN: begin
                                lock_d       = 1'b1;
                                piece_live_d = 1'b0;
                                state_d      = S_LOCK;
                            end
                            default: state_d = S_READY;
                        endcase
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_LOCK: begin
                pending_v_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            kind_q         <= K_SPAWN;
            chk_req_q      <= 1'b0;
            chk_x_q        <= X_ZERO;
            chk_y_q        <= {Y_W{1'b0}};
            chk_rot_q      <= 2'd0;
            piece_x_q      <= X_ZERO;
            piece_y_q      <= {Y_W{1'b0}};
            piece_rot_q    <= 2'd0;
            piece_live_q   <= 1'b0;
            lock_q         <= 1'b0;
            game_over_q    <= 1'b0;
            pending_v_q    <= 1'b0;
            rot_pend_q     <= 1'b0;
            btn_rot_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            chk_req_q      <= chk_req_d;
            chk_x_q        <= chk_x_d;
            chk_y_q        <= chk_y_d;
            chk_rot_q      <= chk_rot_d;
            piece_x_q      <= piece_x_d;
            piece_y_q      <= piece_y_d;
            piece_rot_q    <= piece_rot_d;
            piece_live_q   <= piece_live_d;
            lock_q         <= lock_d;
            game_over_q    <= game_over_d;
            pending_v_q    <= pending_v_d;
            rot_pend_q     <= rot_pend_d;
            btn_rot_prev_q <= btn_rot_prev_d;
        end
    end

    assign chk.chk_req  = chk_req_q;
    assign chk.chk_x    = chk_x_q;
    assign chk.chk_y    = chk_y_q;
    assign chk.chk_rot  = chk_rot_q;
    assign piece_x      = piece_x_q;
    assign piece_y      = piece_y_q;
    assign piece_rot    = piece_rot_q;
    assign piece_live   = piece_live_q;
    assign lock         = lock_q;
    assign game_over    = game_over_q;
endmodule
